// File: rtl/if_id_buf_pkg.sv
// rtl/if_id_buf_pkg.sv - shared CPU constants and the fetch/decode entry type
package if_id_buf_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h00003000;
  localparam logic [31:0] NOP_INSTR        = 32'h00000000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - 2-entry in-order fetch/decode buffer with flush and stall
module if_id_buf
  import if_id_buf_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  input  logic [31:0] PCPlus4F,
  input  logic [31:0] InstrF,
  input  logic        ValidF,
  output logic        ReadyF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic [1:0]  CountD
);

  entry_t      mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic [31:0] hold_pc;
  logic [31:0] hold_pc4;
  logic        accept;
  logic        consume;
  entry_t      head;

  assign head    = mem[rd_ptr];
  assign CountD  = count;
  assign ValidD  = (count != 2'd0);
  assign ReadyF  = (count < 2'd2);
  assign accept  = ValidF & ReadyF & ~FlushD;
  assign consume = ValidD & ~StallD & ~FlushD;

  // With the buffer empty, the PC outputs show the last head that decode saw.
  assign InstrD   = ValidD ? head.instr : NOP_INSTR;
  assign PCD      = ValidD ? head.pc    : hold_pc;
  assign PCPlus4D = ValidD ? head.pc4   : hold_pc4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mem[i] <= '0;
      end
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      hold_pc  <= RESET_PC;
      hold_pc4 <= RESET_PC + 32'd4;
    end else begin
      if (ValidD) begin
        hold_pc  <= head.pc;
        hold_pc4 <= head.pc4;
      end
      if (FlushD) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (accept) begin
          mem[wr_ptr] <= '{pc: PCF, pc4: PCPlus4F, instr: InstrF};
          wr_ptr      <= ~wr_ptr;
        end
        if (consume) begin
          rd_ptr <= ~rd_ptr;
        end
        case ({accept, consume})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h00003000, PC value shown on the D outputs after reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: PCF  input  32  address of the fetched instruction.
REQ-005 SHALL have port: PCPlus4F  input  32  PCF+4 from the fetch stage.
REQ-006 SHALL have port: InstrF  input  32  fetched instruction word.
REQ-007 SHALL have port: ValidF  input  1  fetch offers a valid word this cycle.
REQ-008 SHALL have port: ReadyF  output  1  buffer can accept a word; drives the PC enable.
REQ-009 SHALL have port: StallD  input  1  decode cannot consume the head this cycle.
REQ-010 SHALL have port: FlushD  input  1  taken jump/branch resolved in decode; discard all fetched words.
REQ-011 SHALL have ports: InstrD, PCD, PCPlus4D  output  32 each  head entry presented to decode.
REQ-012 SHALL have port: ValidD  output  1  head entry valid.
REQ-013 SHALL have port: CountD  output  2  occupancy, 0..2.

Function
REQ-014 SHALL be a 2-entry in-order FIFO of {PC, PC+4, Instr}; head drives the D outputs directly from registers (no input-to-output bypass).
REQ-015 SHALL accept the F word at an edge iff ValidF=1 and ReadyF=1 and FlushD=0.
REQ-016 SHALL consume the head at an edge iff ValidD=1 and StallD=0 and FlushD=0.
REQ-017 SHALL compute ReadyF = (CountD < 2) from registered occupancy only.
REQ-018 SHALL give latency 1: a word accepted at edge N into an empty buffer appears on the D outputs with ValidD=1 from edge N to the next consume.
REQ-019 SHALL, with accept and consume at the same edge at CountD=1, leave CountD=1 with the accepted word as the new head.
REQ-020 SHALL, with accept and consume at the same edge at CountD=0, be impossible (ValidD=0); accept alone applies.
REQ-021 SHALL, at CountD=2, hold both entries unchanged while StallD=1; ReadyF=0, so no word is lost.
REQ-022 SHALL, when FlushD=1 at an edge, set CountD=0 and ValidD=0, drop the incoming word, and ignore StallD and ValidF (flush has priority).
REQ-023 SHALL drive InstrD=32'h00000000 (NOP) whenever ValidD=0; PCD/PCPlus4D keep their last values.
REQ-024 SHALL keep ValidD = (CountD != 0) at all times.
REQ-025 SHALL implement the read/write pointers as 1-bit values that wrap 1->0.

Reset
REQ-026 SHALL, while rst=1 and independent of clk, set CountD=0, ValidD=0, ReadyF=1, InstrD=0, PCD=RESET_PC, PCPlus4D=RESET_PC+4, and both pointers to 0.
REQ-027 SHALL discard any in-flight entries when rst asserts mid-operation; the first edge after rst deasserts behaves as an empty buffer.

Structure
REQ-028 SHALL take RESET_PC default and the NOP encoding from the shared CPU constants package, which the PC block also uses.
REQ-029 SHALL be a single module; entry storage is a 2-deep register array inline, with no sub-module.

Verification
REQ-030 SHALL cover: reset, then ValidF=1 with PCF=0x3000, InstrF=0x8C010004, StallD=0 -> the next cycle shows PCD=0x3000, PCPlus4D=0x3004, InstrD=0x8C010004, ValidD=1, CountD=1.
REQ-031 SHALL cover: StallD=1 with ValidF=1 for 3 cycles from empty -> CountD goes 1, 2, 2; ReadyF=0 in the third cycle; the head remains the first word.
REQ-032 SHALL cover: CountD=2 with StallD released -> the words drain in order 0x3000 then 0x3004; the third offered word (0x3008) is accepted once ReadyF=1.
REQ-033 SHALL cover: FlushD=1 with CountD=2 and ValidF=1 -> the next cycle shows CountD=0, ValidD=0, InstrD=0; the incoming word is not stored.
REQ-034 SHALL cover: CountD=1 with accept and consume at the same edge -> CountD stays 1 and the head becomes the new word.
REQ-035 SHALL cover: rst pulsed between clock edges with CountD=2 -> outputs go to reset values immediately, before the next edge.
